// File: rtl/addr_range_coalesce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : addr_range_coalesce                                           |
// | Purpose  : Merges runs of contiguous {fdssi, s_addr, e_addr} ranges that |
// |            share an FDSSI into single ranges and reports how many source |
// |            entries each merged range absorbed. One copy sits behind each |
// |            per-FDSTI address FIFO.                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           in   clock (single domain)                               |
// |   rst_n         in   synchronous active-low reset                        |
// |   s_addr_valid  in   input entry valid                                   |
// |   s_addr_ready  out  input entry accepted when high with valid           |
// |   s_addr        in   {fdssi, s_addr, e_addr}                             |
// |   flush         in   end-of-input pulse, closes the held range           |
// |   m_addr_valid  out  merged range valid                                  |
// |   m_addr_ready  in   downstream accept                                   |
// |   m_addr        out  merged {fdssi, s_addr, e_addr}                      |
// |   m_addr_cnt    out  number of input entries merged into m_addr          |
// |   flush_done    out  pulse: held range handed to the output register     |
// |   err_drop      out  pulse: malformed entry (e_addr < s_addr) discarded  |
// +--------------------------------------------------------------------------+
// | Build option                                                             |
// |   ADDR_COALESCE_OVERLAP_EN : also merge overlapping ranges               |
// |                              (h_s <= s_addr <= h_e + 1, h_e = max).      |
// |   Undefined                : only exact adjacency (s_addr == h_e + 1).   |
// +--------------------------------------------------------------------------+
module addr_range_coalesce #(
  parameter int I_FDSSI_WIDTH    = 12,
  parameter int AWIDTH           = 32,
  parameter int CNT_WIDTH        = 16,
  parameter int MAX_SPAN         = 4096,
  parameter int T_ADDR_INFO_WITH = I_FDSSI_WIDTH + 2 * AWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_addr_valid,
  output logic                        s_addr_ready,
  input  logic [T_ADDR_INFO_WITH-1:0] s_addr,
  input  logic                        flush,
  output logic                        m_addr_valid,
  input  logic                        m_addr_ready,
  output logic [T_ADDR_INFO_WITH-1:0] m_addr,
  output logic [CNT_WIDTH-1:0]        m_addr_cnt,
  output logic                        flush_done,
  output logic                        err_drop
);

  // Span arithmetic is carried one bit wider than the address so that
  // h_e + 1 at the top of the address space cannot alias to zero.
  localparam logic [AWIDTH:0]      SPAN_LIMIT = (AWIDTH + 1)'(MAX_SPAN);
  localparam logic [AWIDTH:0]      ONE_W      = (AWIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,   // nothing held
    ST_ACC   = 2'd1,   // a range is held and may still grow
    ST_DRAIN = 2'd2    // flush pending, held range must be emitted
  } state_t;

  state_t state;
  state_t state_nxt;

  // Hold register
  logic [I_FDSSI_WIDTH-1:0] h_fdssi;
  logic [AWIDTH-1:0]        h_s;
  logic [AWIDTH-1:0]        h_e;
  logic [CNT_WIDTH-1:0]     h_cnt;

  // Incoming entry fields
  logic [I_FDSSI_WIDTH-1:0] in_fdssi;
  logic [AWIDTH-1:0]        in_s;
  logic [AWIDTH-1:0]        in_e;

  logic              out_free;
  logic              accept;
  logic              malformed;
  logic              take;
  logic [AWIDTH:0]   h_e_inc;
  logic              contig;
  logic [AWIDTH-1:0] merged_e;
  logic [AWIDTH:0]   span;
  logic              mergeable;

  // Control decoded by the next-state process
  logic load_new;
  logic merge;
  logic push_hold;
  logic clear_hold;
  logic flush_done_nxt;
  logic err_drop_nxt;

  assign {in_fdssi, in_s, in_e} = s_addr;

  // The output register can take a new range when it is empty or its
  // current content leaves in this same cycle.
  assign out_free     = !m_addr_valid || m_addr_ready;
  assign s_addr_ready = (state != ST_DRAIN) && out_free;
  assign accept       = s_addr_valid && s_addr_ready;
  assign malformed    = (in_e < in_s);
  assign take         = accept && !malformed;

  assign h_e_inc = {1'b0, h_e} + ONE_W;

`ifdef ADDR_COALESCE_OVERLAP_EN
  // Any entry starting inside the held range or right after it extends it.
  assign contig   = (in_s >= h_s) && ({1'b0, in_s} <= h_e_inc);
  assign merged_e = (in_e > h_e) ? in_e : h_e;
`else
  // Exact adjacency only; overlapping entries start a new range.
  assign contig   = ({1'b0, in_s} == h_e_inc);
  assign merged_e = in_e;
`endif

  assign span = {1'b0, merged_e} - {1'b0, h_s} + ONE_W;

  // A saturated counter closes the range rather than wrapping.
  assign mergeable = (in_fdssi == h_fdssi) && contig &&
                     (span <= SPAN_LIMIT) && (h_cnt != '1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    load_new       = 1'b0;
    merge          = 1'b0;
    push_hold      = 1'b0;
    clear_hold     = 1'b0;
    flush_done_nxt = 1'b0;
    err_drop_nxt   = accept && malformed;

    case (state)
      ST_IDLE: begin
        if (take) begin
          load_new  = 1'b1;
          state_nxt = ST_ACC;
        end
        // A flush arriving with an entry includes that entry in the drain;
        // with nothing to drain it is acknowledged straight away.
        if (flush) begin
          if (take) begin
            state_nxt = ST_DRAIN;
          end else begin
            flush_done_nxt = 1'b1;
          end
        end
      end

      ST_ACC: begin
        // take implies out_free, so pushing the hold here never overwrites
        // an output that has not been accepted.
        if (take) begin
          if (mergeable) begin
            merge = 1'b1;
          end else begin
            push_hold = 1'b1;
            load_new  = 1'b1;
          end
        end
        if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Further flush pulses are ignored here; input is stalled.
        if (out_free) begin
          push_hold      = 1'b1;
          clear_hold     = 1'b1;
          flush_done_nxt = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Hold register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_fdssi <= '0;
      h_s     <= '0;
      h_e     <= '0;
      h_cnt   <= '0;
    end else if (load_new) begin
      h_fdssi <= in_fdssi;
      h_s     <= in_s;
      h_e     <= in_e;
      h_cnt   <= CNT_ONE;
    end else if (merge) begin
      h_e     <= merged_e;
      h_cnt   <= h_cnt + CNT_ONE;
    end else if (clear_hold) begin
      h_fdssi <= '0;
      h_s     <= '0;
      h_e     <= '0;
      h_cnt   <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Output register and status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_addr_valid <= 1'b0;
      m_addr       <= '0;
      m_addr_cnt   <= '0;
      flush_done   <= 1'b0;
      err_drop     <= 1'b0;
    end else begin
      flush_done <= flush_done_nxt;
      err_drop   <= err_drop_nxt;
      if (push_hold) begin
        m_addr_valid <= 1'b1;
        m_addr       <= {h_fdssi, h_s, h_e};
        m_addr_cnt   <= h_cnt;
      end else if (m_addr_ready) begin
        m_addr_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_range_coalesce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_addr_range_coalesce                                        |
// | Purpose  : Self-checking bench for addr_range_coalesce. A transaction-   |
// |            level model turns the accepted entry/flush sequence into the |
// |            list of expected merged ranges. A second instance with a     |
// |            small span limit and a 2-bit counter covers those limits.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_addr_range_coalesce;

  localparam int FW = 12;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int MS = 4096;
  localparam int TW = FW + 2 * AW;

  typedef struct packed {
    logic [TW-1:0] a;
    logic [CW-1:0] c;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_data;
  logic          in_flush;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          fd_pulse;
  logic          err_pulse;

  logic          b_valid;
  logic          b_ready;
  logic [TW-1:0] b_data;
  logic          b_flush;
  logic          b_mvalid;
  logic          b_mready;
  logic [TW-1:0] b_maddr;
  logic [1:0]    b_mcnt;
  logic          b_fd;
  logic          b_err;

  always #5 clk = ~clk;

  addr_range_coalesce #(
    .I_FDSSI_WIDTH(FW), .AWIDTH(AW), .CNT_WIDTH(CW), .MAX_SPAN(MS)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_addr_valid(in_valid), .s_addr_ready(in_ready), .s_addr(in_data),
    .flush(in_flush),
    .m_addr_valid(out_valid), .m_addr_ready(out_ready), .m_addr(out_data),
    .m_addr_cnt(out_cnt), .flush_done(fd_pulse), .err_drop(err_pulse)
  );

  addr_range_coalesce #(
    .I_FDSSI_WIDTH(FW), .AWIDTH(AW), .CNT_WIDTH(2), .MAX_SPAN(512)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n),
    .s_addr_valid(b_valid), .s_addr_ready(b_ready), .s_addr(b_data),
    .flush(b_flush),
    .m_addr_valid(b_mvalid), .m_addr_ready(b_mready), .m_addr(b_maddr),
    .m_addr_cnt(b_mcnt), .flush_done(b_fd), .err_drop(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Downstream ready: fixed level or random back-pressure
  // --------------------------------------------------------------------------
  bit   bp_mode  = 1'b0;
  logic bp_level = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : bp_level;
  end

  // --------------------------------------------------------------------------
  // Monitor (samples on the falling edge)
  // --------------------------------------------------------------------------
  xfer_t         obs_q[$];
  logic [TW+1:0] obs2_q[$];
  int            fd_seen  = 0;
  int            err_seen = 0;
  int            fd2_seen = 0;
  bit            stall_prev = 1'b0;
  xfer_t         stall_v;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", 128'(out_valid), 128'(1'b1));
        chk("stall_data", 128'({out_data, out_cnt}), 128'(stall_v));
      end
      if (out_valid && out_ready) obs_q.push_back({out_data, out_cnt});
      if (fd_pulse) fd_seen++;
      if (err_pulse) err_seen++;
      if (b_mvalid) obs2_q.push_back({b_maddr, b_mcnt});
      if (b_fd) fd2_seen++;
      stall_prev = out_valid && !out_ready;
      stall_v    = {out_data, out_cnt};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: applies the merge rules to the accepted entry sequence
  // --------------------------------------------------------------------------
  xfer_t         exp_q[$];
  bit            mh = 1'b0;
  logic [FW-1:0] hf;
  logic [AW-1:0] hs, he;
  int            hc;
  int            exp_fd  = 0;
  int            exp_err = 0;

  function automatic void m_accept(input logic [FW-1:0] f, input logic [AW-1:0] s, input logic [AW-1:0] e);
    longint ls  = s;
    longint le  = e;
    longint lhs = hs;
    longint lhe = he;
    longint ne  = 0;
    bit     ok  = 1'b0;
    if (le < ls) begin
      exp_err++;
      return;
    end
    if (mh && f == hf && hc < (1 << CW) - 1) begin
`ifdef ADDR_COALESCE_OVERLAP_EN
      ne = (le > lhe) ? le : lhe;
      ok = (ls >= lhs) && (ls <= lhe + 1);
`else
      ne = le;
      ok = (ls == lhe + 1);
`endif
      ok = ok && (ne - lhs + 1 <= MS);
    end
    if (ok) begin
      he = AW'(ne);
      hc++;
    end else begin
      if (mh) exp_q.push_back({hf, hs, he, CW'(hc)});
      mh = 1'b1;
      hf = f;
      hs = s;
      he = e;
      hc = 1;
    end
  endfunction

  function automatic void m_flush();
    if (mh) exp_q.push_back({hf, hs, he, CW'(hc)});
    mh = 1'b0;
    exp_fd++;
  endfunction

  // --------------------------------------------------------------------------
  // Drivers (every task starts and ends just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic wait_fd();
    int n = 0;
    while (fd_seen < exp_fd && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("flush_done_seen", 128'(fd_seen), 128'(exp_fd));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [FW-1:0] f, input logic [AW-1:0] s, input logic [AW-1:0] e, input bit fl);
    int n    = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = {f, s, e};
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        in_flush = fl;
        m_accept(f, s, e);
        if (fl) m_flush();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        done     = 1'b1;
      end else if (++n > 300) begin
        chk("send_ready", 128'(in_ready), 128'(1'b1));
        in_valid = 1'b0;
        done     = 1'b1;
        @(posedge clk); #1;
      end
    end
    if (fl) wait_fd();
  endtask

  task automatic do_flush(input int cycles);
    in_flush = 1'b1;
    m_flush();
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    in_flush = 1'b0;
    wait_fd();
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((obs_q.size() < exp_q.size() || fd_seen < exp_fd) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_range"}, 128'(obs_q.pop_front()), 128'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_flush_done"}, 128'(fd_seen), 128'(exp_fd));
    chk({tag, "_err_drop"}, 128'(err_seen), 128'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit fl);
    int n = 0;
    b_valid = 1'b1;
    b_data  = {12'd5, s, e};
    @(negedge clk);
    while (!b_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("small_ready", 128'(b_ready), 128'(1'b1));
    b_flush = fl;
    @(posedge clk); #1;
    b_valid = 1'b0;
    b_flush = 1'b0;
  endtask

  task automatic check_b(input string tag, input logic [TW+1:0] e0, input logic [TW+1:0] e1);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 128'(obs2_q.size()), 128'(2));
    if (obs2_q.size() > 0) chk({tag, "_first"}, 128'(obs2_q.pop_front()), 128'(e0));
    if (obs2_q.size() > 0) chk({tag, "_second"}, 128'(obs2_q.pop_front()), 128'(e1));
    obs2_q.delete();
    @(posedge clk); #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [AW-1:0] last_e;
    logic [AW-1:0] rs, re;
    logic [FW-1:0] rf;
    int            r;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_data  = '0;
    b_valid  = 1'b0;
    b_flush  = 1'b0;
    b_data   = '0;
    b_mready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_m_addr", 128'(out_data), 128'(0));
    chk("rst_m_cnt", 128'(out_cnt), 128'(0));
    chk("rst_flush_done", 128'(fd_pulse), 128'(1'b0));
    chk("rst_err_drop", 128'(err_pulse), 128'(1'b0));
    chk("rst_s_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three adjacent entries collapse into one range
    send(12'd3, 32'h100, 32'h1FF, 1'b0);
    send(12'd3, 32'h200, 32'h2FF, 1'b0);
    send(12'd3, 32'h300, 32'h30F, 1'b0);
    do_flush(1);
    settle("adjacent3");

    // Different FDSSI never merges
    send(12'd3, 32'h100, 32'h1FF, 1'b0);
    send(12'd4, 32'h200, 32'h2FF, 1'b0);
    do_flush(1);
    settle("fdssi_change");

    // Span exactly at the limit merges, one beyond does not; flush shares
    // the cycle of the last accepted entry
    send(12'd1, 32'h0, 32'h7FF, 1'b0);
    send(12'd1, 32'h800, 32'hFFF, 1'b0);
    send(12'd1, 32'h1000, 32'h10FF, 1'b0);
    send(12'd1, 32'h1100, 32'h11FF, 1'b1);
    settle("span_limit");

    // No merge across the address wrap; malformed entry dropped
    send(12'd7, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b0);
    send(12'd7, 32'h0, 32'hFF, 1'b0);
    send(12'd7, 32'h50, 32'h40, 1'b0);
    do_flush(1);
    settle("wrap_malformed");

    // Flush alongside a malformed entry with nothing held
    send(12'd7, 32'h50, 32'h40, 1'b1);
    settle("idle_flush");

    // Back-pressure: the second non-adjacent accept fills the output
    @(negedge clk);
    bp_level = 1'b0;
    @(posedge clk); #1;
    send(12'd2, 32'h1000, 32'h10FF, 1'b0);
    send(12'd2, 32'h3000, 32'h30FF, 1'b0);
    in_valid = 1'b1;
    in_data  = {12'd2, 32'h5000, 32'h50FF};
    repeat (10) begin
      @(negedge clk);
      chk("bp_s_ready_low", 128'(in_ready), 128'(1'b0));
    end
    bp_level = 1'b1;
    send(12'd2, 32'h5000, 32'h50FF, 1'b1);
    settle("backpressure");

    // Overlapping entries: merged only with the overlap build option
    send(12'd3, 32'h100, 32'h1FF, 1'b0);
    send(12'd3, 32'h180, 32'h27F, 1'b0);
    do_flush(1);
    settle("overlap");

    // Second flush cycle lands in DRAIN and is ignored
    send(12'd9, 32'h40, 32'h4F, 1'b0);
    do_flush(2);
    settle("double_flush");

    // Reset mid-operation discards the held range
    send(12'd5, 32'h10, 32'h1F, 1'b0);
    rst_n = 1'b0;
    mh    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", 128'(out_valid), 128'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_flush(1);
    settle("mid_reset");

    // Small instance: span limit 0x200 and 2-bit counter saturation
    send_b(32'h000, 32'h0FF, 1'b0);
    send_b(32'h100, 32'h1FF, 1'b0);
    send_b(32'h200, 32'h2FF, 1'b1);
    check_b("small_span", {12'd5, 32'h0, 32'h1FF, 2'd2}, {12'd5, 32'h200, 32'h2FF, 2'd1});
    send_b(32'h1000, 32'h100F, 1'b0);
    send_b(32'h1010, 32'h101F, 1'b0);
    send_b(32'h1020, 32'h102F, 1'b0);
    send_b(32'h1030, 32'h103F, 1'b1);
    check_b("small_cnt_sat", {12'd5, 32'h1000, 32'h102F, 2'd3}, {12'd5, 32'h1030, 32'h103F, 2'd1});
    chk("small_flush_done", 128'(fd2_seen), 128'(2));

    // Random traffic under random back-pressure
    bp_mode = 1'b1;
    last_e  = 32'h0;
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      rf = 12'($urandom_range(1, 2));
      case (r)
        0:       rs = last_e + 32'd10;
        7:       rs = last_e - 32'h10;
        8:       rs = $urandom;
        9:       rs = 32'hFFFFF000 + 32'($urandom_range(0, 16'hFFF));
        default: rs = last_e + 32'd1;
      endcase
      re = (r == 0) ? rs - 32'd5 : rs + 32'($urandom_range(0, 16'h3FF));
      if (r != 0) last_e = re;
      send(rf, rs, re, $urandom_range(0, 19) == 0);
    end
    do_flush(1);
    bp_mode = 1'b0;
    settle("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/addr_range_coalesce.md
# addr_range_coalesce

Downstream stage of the per-FDSTI address FIFOs. Consumes one FDSTI stream of `{fdssi, s_addr, e_addr}` entries and merges runs of contiguous ranges from the same FDSSI into single ranges. Emits each merged range with a count of the source entries it absorbed. Instantiated once per FDSTI FIFO output (`2**O_TAM_WIDTH` copies).

## Interface
- `I_FDSSI_WIDTH`, 12: FDSSI field width.
- `AWIDTH`, 32: address width.
- `CNT_WIDTH`, 16: merged-entry counter width.
- `MAX_SPAN`, 4096: maximum merged length `e_addr - s_addr + 1`, in address units.
- `T_ADDR_INFO_WITH`, `I_FDSSI_WIDTH+2*AWIDTH`: entry width, derived.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_addr_valid`  in  1  input entry valid.
- `s_addr_ready`  out  1  input entry accepted when high together with valid.
- `s_addr`  in  T_ADDR_INFO_WITH  `{fdssi[MSBs], s_addr, e_addr[LSBs]}`.
- `flush`  in  1  end-of-input pulse; closes the held range.
- `m_addr_valid`  out  1  merged range valid.
- `m_addr_ready`  in  1  downstream accept.
- `m_addr`  out  T_ADDR_INFO_WITH  merged `{fdssi, s_addr, e_addr}`.
- `m_addr_cnt`  out  CNT_WIDTH  number of input entries merged into `m_addr`.
- `flush_done`  out  1  one-cycle pulse: held range handed to output register.
- `err_drop`  out  1  one-cycle pulse: malformed entry discarded.

## Operation
- Registers: hold (`h_fdssi`, `h_s`, `h_e`, `h_cnt`); output register (`m_addr`, `m_addr_cnt`, `m_addr_valid`).
- FSM states:
  - IDLE: nothing held.
  - ACC: range held.
  - DRAIN: flush pending; hold must be emitted.
- `s_addr_ready = (state != DRAIN) && (!m_addr_valid || m_addr_ready)`.
- Malformed entry (`e_addr < s_addr`): accepted, discarded, `err_drop` pulses, state unchanged.
- Accepted entry in IDLE: load hold, `h_cnt = 1`, go to ACC.
- Accepted entry in ACC: mergeable only if all of the following hold:
  - same fdssi;
  - `{1'b0,s_addr} == {1'b0,h_e} + 1`, computed in AWIDTH+1 bits, so no merge across address wrap;
  - `e_addr - h_s + 1 <= MAX_SPAN`, computed in AWIDTH+1 bits;
  - `h_cnt != all-ones`.
- If mergeable: `h_e <= e_addr`, `h_cnt++`.
- Otherwise: hold moves to the output register and the new entry loads into hold with `h_cnt = 1`.
- `flush` seen in ACC (or in the same cycle as an accepted entry): go to DRAIN. The entry accepted in that cycle is processed first and is included in the drained range.
- DRAIN: when the output register is free or being accepted, hold moves to output, `flush_done` pulses, go to IDLE.
- `flush` in IDLE with no accepted entry: `flush_done` pulses next cycle, no output.
- `flush` while already in DRAIN: ignored.

## Timing
- Reset (`rst_n` low at a `clk` edge):
  - state IDLE;
  - `m_addr_valid`, `m_addr`, `m_addr_cnt`, `flush_done`, `err_drop` all 0;
  - hold cleared.
- Reset mid-operation discards the held range and any pending output.
- A closed range is visible on `m_addr` one cycle after the closing event: a non-mergeable input accept, or DRAIN transfer.
- `m_addr`/`m_addr_cnt` stay stable while `m_addr_valid && !m_addr_ready`. `m_addr_valid` never drops without handshake.
- Throughput: one input per cycle while the output is not back-pressured.
- The last range of a stream is emitted only via `flush`.

## Configuration
- `ADDR_COALESCE_OVERLAP_EN` defined:
  - the contiguity test becomes `h_s <= s_addr <= h_e + 1`;
  - `h_e <= max(h_e, e_addr)`;
  - the MAX_SPAN check uses the new `h_e`.
- Undefined: only exact adjacency (`s_addr == h_e + 1`) merges; overlapping entries start a new range.

## Test plan
- Entries fdssi=3: [0x100,0x1FF], [0x200,0x2FF], [0x300,0x30F], then flush -> one output {3,0x100,0x30F}, cnt=3; `flush_done` pulses.
- [0x100,0x1FF] fdssi=3, then [0x200,0x2FF] fdssi=4, flush -> two outputs, cnt=1 each, in input order.
- MAX_SPAN=0x200: [0x000,0x0FF], [0x100,0x1FF], [0x200,0x2FF], flush -> {0x000,0x1FF} cnt=2, then {0x200,0x2FF} cnt=1.
- [0xFFFFFF00,0xFFFFFFFF], then [0x0,0xFF], same fdssi -> no merge (wrap); [0x50,0x40] -> `err_drop` pulse, no output.
- `m_addr_ready` held low 10 cycles with 3 non-adjacent inputs offered -> `s_addr_ready` low after 2 accepts; output stable; no loss after release.
- With `ADDR_COALESCE_OVERLAP_EN`: [0x100,0x1FF], then [0x180,0x27F] -> {0x100,0x27F} cnt=2. Without the macro -> two outputs.
